coso_entropy_collector: RTL and testbench
=========================================

Name: coso_entropy_collector

Overview:
Downstream consumer of the coherent sampler. It synchronises the sampler's asynchronous req into the system clock domain and captures the stable counter value. It completes the req/ack four-phase handshake, extracts the counter LSBs as raw random bits, and packs them into OUT_WIDTH-bit words on a valid/ready stream. It also exports each raw counter value for off-line quality and frequency-tuning analysis.

Parameters:
CNT_WIDTH, 16, width of sampler counter input
BITS_PER_SAMPLE, 1, number of counter LSBs taken per sample (1..CNT_WIDTH)
OUT_WIDTH, 32, packed output word width; must be an integer multiple of BITS_PER_SAMPLE
SYNC_STAGES, 2, flip-flop stages in the req synchroniser (>=2)
RCT_LIMIT, 8, consecutive identical counter values that trigger an alarm (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset rst, synchronous, active-high
smp_cnt  in  CNT_WIDTH  sampler counter; stable whenever smp_req is high
smp_req  in  1  sampler request, asynchronous to clk
smp_ack  out  1  acknowledge to sampler
out_data  out  OUT_WIDTH  packed random word
out_valid  out  1  out_data holds a word
out_ready  in  1  consumer accepts the word on clk edge when out_valid=1
raw_cnt  out  CNT_WIDTH  last captured counter value
raw_valid  out  1  one-cycle pulse when raw_cnt updates
health_alarm  out  1  sticky repetition alarm; cleared only by rst

Behaviour:
- Reset values: smp_ack=0, out_valid=0, out_data=0, raw_cnt=0, raw_valid=0, health_alarm=0. Synchroniser cleared, packer bit count=0, FSM=IDLE.
- req_sync is smp_req delayed through SYNC_STAGES flops. smp_cnt is sampled only while req_sync=1, so no synchroniser is needed on smp_cnt.
- FSM states IDLE, ACK.
  - IDLE: if req_sync=1 and room=1 -> on that edge raw_cnt<=smp_cnt, raw_valid<=1 for one cycle, shift raw bits into the packer, smp_ack<=1, go to ACK.
  - IDLE with req_sync=1 and room=0: stay in IDLE and do not capture. The sampler stalls because req stays high.
  - ACK: hold smp_ack=1 until req_sync=0. On that edge smp_ack<=0 and go to IDLE. req_sync is never re-evaluated for a new sample until ack has dropped.
- Packer: shift register of OUT_WIDTH bits, LSB-first. The new smp_cnt[BITS_PER_SAMPLE-1:0] enters at the MSB end and the register shifts right by BITS_PER_SAMPLE. A bit counter counts to OUT_WIDTH.
  - When the count reaches OUT_WIDTH on a capture edge, the word moves to out_data, out_valid goes to 1, and the count resets to 0. This happens on the same edge as the capture that completes the word.
- room=0 only when out_valid=1, out_ready=0, and the next capture would complete a word. Otherwise room=1. Partial words keep accumulating while out_valid=1.
- out_valid falls on the edge where out_valid=1 and out_ready=1, unless a new word completes on the same edge. In that case out_data is reloaded and out_valid stays 1.
- Latency: smp_req rise -> smp_ack rise = SYNC_STAGES+1 clk cycles when room=1.
- rst mid-handshake: ack drops immediately and the FSM returns to IDLE. A still-high smp_req is then treated as a fresh sample after synchronisation. The partial word is discarded.
- Counter wrap inside the sampler is invisible here; only the LSBs are used.

Optional Feature:
Macro COSO_RCT_EN.
- Defined: a repetition-count test runs on each captured smp_cnt. If a value equals the previous captured value for RCT_LIMIT consecutive captures (first capture counts 1), health_alarm<=1 and stays set. The run counter saturates.
- Undefined: health_alarm is tied 0 and the RCT logic is absent.

Decomposition:
Shared package holds FSM state encoding (IDLE, ACK) and the width-check constant OUT_WIDTH % BITS_PER_SAMPLE == 0, asserted at elaboration. The natural sub-module is coso_req_sync, a SYNC_STAGES-flop synchroniser with synchronous reset. Packer, FSM and RCT live in the top module.

Test Plan:
- Single sample: rst 4 cycles, smp_cnt=16'h00A5, raise smp_req. smp_ack rises SYNC_STAGES+1=3 cycles later; raw_cnt=16'h00A5 with a 1-cycle raw_valid. Drop smp_req; smp_ack falls 2–3 cycles later.
- Packing: 32 samples with LSBs alternating 1,0,1,0… (first=1), out_ready=1. Expect out_data=32'h55555555 and out_valid high exactly one cycle.
- Backpressure: out_ready=0, feed 64 samples. First word is held. The 64th sample's req is never acked while out_ready=0. Raising out_ready gives the second word, then an ack within 3 cycles.
- Reset mid-handshake: assert rst while in ACK. smp_ack=0 next cycle, out_valid=0; a still-high req is acked again after synchronisation.
- BITS_PER_SAMPLE=4, OUT_WIDTH=16: samples 0x1,0x2,0x3,0x4 give out_data=16'h4321.
- COSO_RCT_EN defined, RCT_LIMIT=8: 7 identical captures of 16'h0003 leave health_alarm=0. The 8th sets it to 1; it stays 1 after differing values until rst.

Source files
------------

// File: rtl/coso_entropy_collector_pkg.sv
// Shared FSM encoding and parameter sanity check for the CoSo entropy collector.
package coso_entropy_collector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // Packed word must hold a whole number of samples.
  function automatic bit width_ok(input int out_w, input int bps);
    return (bps >= 1) && (out_w >= bps) && ((out_w % bps) == 0);
  endfunction

endpackage

// File: rtl/coso_req_sync.sv
// Multi-flop synchroniser bringing the sampler's asynchronous req into clk.
module coso_req_sync
  import coso_entropy_collector_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/coso_entropy_collector.sv
// Captures sampler counter on synchronised req, acks it, packs LSBs into words; raw value exported.
// Latency: smp_req rise -> smp_ack rise SYNC_STAGES+1 cycles; packed word valid on the completing capture edge.
// Backpressure: a completing sample is not acked while a word is held unaccepted. COSO_RCT_EN adds repetition alarm.
module coso_entropy_collector
  import coso_entropy_collector_pkg::*;
#(
  parameter int CNT_WIDTH       = 16,
  parameter int BITS_PER_SAMPLE = 1,
  parameter int OUT_WIDTH       = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int RCT_LIMIT       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] smp_cnt,
  input  logic                 smp_req,
  output logic                 smp_ack,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] raw_cnt,
  output logic                 raw_valid,
  output logic                 health_alarm
);

  localparam int BCW = $clog2(OUT_WIDTH + 1);

  generate
    if (!width_ok(OUT_WIDTH, BITS_PER_SAMPLE)) begin : g_bad_width
      $error("OUT_WIDTH must be a multiple of BITS_PER_SAMPLE");
    end
  endgenerate

  logic req_sync;

  coso_req_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(smp_req),
    .sync_o (req_sync)
  );

  state_e               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [OUT_WIDTH-1:0] shift_q, shift_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] raw_cnt_q, raw_cnt_d;
  logic                 raw_valid_q, raw_valid_d;

  logic will_complete;
  logic room;
  logic capture;

  assign will_complete = (bit_cnt_q == BCW'(OUT_WIDTH - BITS_PER_SAMPLE));
  // Refuse only the sample that would overwrite a word still waiting for the consumer.
  assign room    = !(out_valid_q && !out_ready && will_complete);
  assign capture = (state_q == IDLE) && req_sync && room;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    raw_cnt_d   = raw_cnt_q;
    raw_valid_d = 1'b0;

    case (state_q)
      IDLE: if (capture)   state_d = ACK;
      ACK:  if (!req_sync) state_d = IDLE;
      default:             state_d = IDLE;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (capture) begin
      raw_cnt_d   = smp_cnt;
      raw_valid_d = 1'b1;
      shift_d     = (shift_q >> BITS_PER_SAMPLE)
                  | (OUT_WIDTH'(smp_cnt[BITS_PER_SAMPLE-1:0]) << (OUT_WIDTH - BITS_PER_SAMPLE));
      if (will_complete) begin
        bit_cnt_d   = '0;
        out_data_d  = shift_d;
        out_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BCW'(BITS_PER_SAMPLE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      raw_cnt_q   <= '0;
      raw_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      raw_cnt_q   <= raw_cnt_d;
      raw_valid_q <= raw_valid_d;
    end
  end

  assign smp_ack   = (state_q == ACK);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign raw_cnt   = raw_cnt_q;
  assign raw_valid = raw_valid_q;

`ifdef COSO_RCT_EN
  localparam int RCW = $clog2(RCT_LIMIT + 1);

  logic [CNT_WIDTH-1:0] rct_prev_q, rct_prev_d;
  logic [RCW-1:0]       rct_run_q, rct_run_d;
  logic                 alarm_q, alarm_d;

  // A run length of zero means nothing captured yet, so the first capture starts at one.
  always_comb begin
    rct_prev_d = rct_prev_q;
    rct_run_d  = rct_run_q;
    alarm_d    = alarm_q;
    if (capture) begin
      rct_prev_d = smp_cnt;
      if ((rct_run_q != '0) && (smp_cnt == rct_prev_q)) begin
        if (rct_run_q != RCW'(RCT_LIMIT)) rct_run_d = rct_run_q + RCW'(1);
      end else begin
        rct_run_d = RCW'(1);
      end
      if (rct_run_d == RCW'(RCT_LIMIT)) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rct_prev_q <= '0;
      rct_run_q  <= '0;
      alarm_q    <= 1'b0;
    end else begin
      rct_prev_q <= rct_prev_d;
      rct_run_q  <= rct_run_d;
      alarm_q    <= alarm_d;
    end
  end

  assign health_alarm = alarm_q;
`else
  assign health_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_coso_entropy_collector.sv
// Directed bench: handshake latency, packing, backpressure, reset mid-handshake, 4-bit packing, RCT alarm.
module tb_coso_entropy_collector;

`ifdef COSO_RCT_EN
  localparam logic RCT_EXP = 1'b1;
`else
  localparam logic RCT_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] smp_cnt = '0;
  logic        smp_req = 1'b0;
  logic        smp_ack;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] raw_cnt;
  logic        raw_valid;
  logic        health_alarm;

  logic [15:0] cnt2 = '0;
  logic        req2 = 1'b0;
  logic        ack2;
  logic [15:0] data2;
  logic        valid2;
  logic [15:0] raw2;
  logic        raw_valid2;
  logic        alarm2;

  int n_checks = 0;
  int n_fail   = 0;

  int          vld_cnt  = 0;
  logic [31:0] last_word = '0;
  int          vld_cnt2 = 0;
  logic [15:0] last_word2 = '0;

  always #5 clk = ~clk;

  coso_entropy_collector u_dut (
    .clk         (clk),
    .rst         (rst),
    .smp_cnt     (smp_cnt),
    .smp_req     (smp_req),
    .smp_ack     (smp_ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .raw_cnt     (raw_cnt),
    .raw_valid   (raw_valid),
    .health_alarm(health_alarm)
  );

  coso_entropy_collector #(
    .CNT_WIDTH      (16),
    .BITS_PER_SAMPLE(4),
    .OUT_WIDTH      (16)
  ) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .smp_cnt     (cnt2),
    .smp_req     (req2),
    .smp_ack     (ack2),
    .out_data    (data2),
    .out_valid   (valid2),
    .out_ready   (1'b1),
    .raw_cnt     (raw2),
    .raw_valid   (raw_valid2),
    .health_alarm(alarm2)
  );

  always @(negedge clk) begin
    if (out_valid) begin
      vld_cnt   <= vld_cnt + 1;
      last_word <= out_data;
    end
    if (valid2) begin
      vld_cnt2   <= vld_cnt2 + 1;
      last_word2 <= data2;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full four-phase handshake on one instance; called and returns on a negedge.
  task automatic send(input bit which, input logic [15:0] v);
    int n;
    if (which) begin cnt2 = v; req2 = 1'b1; end
    else       begin smp_cnt = v; smp_req = 1'b1; end
    n = 0;
    while (!(which ? ack2 : smp_ack) && n < 50) begin @(negedge clk); n++; end
    check("send_ack_rise", which ? ack2 : smp_ack, 1);
    if (which) req2 = 1'b0; else smp_req = 1'b0;
    n = 0;
    while ((which ? ack2 : smp_ack) && n < 50) begin @(negedge clk); n++; end
    check("send_ack_fall", which ? ack2 : smp_ack, 0);
  endtask

  initial begin
    int n;
    int base;
    logic lsb;

    @(negedge clk);
    do_reset();
    check("rst_ack",       smp_ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_raw_cnt",   raw_cnt, 0);
    check("rst_raw_valid", raw_valid, 0);
    check("rst_alarm",     health_alarm, 0);

    // Single sample: ack latency and raw export
    smp_cnt = 16'h00A5;
    smp_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!smp_ack && n < 20);
    check("ack_latency", n, 3);
    check("raw_cnt_a5", raw_cnt, 16'h00A5);
    check("raw_valid_pulse", raw_valid, 1);
    @(negedge clk);
    check("raw_valid_drop", raw_valid, 0);
    check("ack_held", smp_ack, 1);
    smp_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (smp_ack && n < 20);
    check("ack_fall_window", (n >= 2 && n <= 3), 1);

    // Packing 1,0,1,0... into 0x55555555
    do_reset();
    out_ready = 1'b1;
    base = vld_cnt;
    for (int i = 0; i < 32; i++) send(0, (i % 2 == 0) ? 16'h0011 : 16'h0010);
    repeat (3) @(negedge clk);
    check("pack_word", last_word, 32'h5555_5555);
    check("pack_valid_cycles", vld_cnt - base, 1);

    // Backpressure: word1 0x0000FFFF held, 64th sample stalls
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 63; i++) begin
      lsb = (i < 32) ? (i < 16) : (((i - 32) % 4) == 0);
      send(0, 16'(i << 1) | {15'd0, lsb});
    end
    check("bp_valid_held", out_valid, 1);
    check("bp_word1", out_data, 32'h0000_FFFF);
    smp_cnt = 16'(63 << 1);
    smp_req = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_no_ack", smp_ack, 0);
    check("bp_word1_still", out_data, 32'h0000_FFFF);
    out_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!smp_ack && n < 20);
    check("bp_ack_after_ready", (n >= 1 && n <= 3), 1);
    check("bp_word2", out_data, 32'h1111_1111);
    check("bp_word2_valid", out_valid, 1);
    smp_req = 1'b0;
    n = 0;
    while (smp_ack && n < 20) begin @(negedge clk); n++; end
    check("bp_ack_fall", smp_ack, 0);

    // Reset mid-handshake discards partial word
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(0, 16'h00F1);
    smp_cnt = 16'h0001;
    smp_req = 1'b1;
    n = 0;
    while (!smp_ack && n < 20) begin @(negedge clk); n++; end
    check("mid_ack_up", smp_ack, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", smp_ack, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_raw", raw_cnt, 0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!smp_ack && n < 20);
    check("mid_reack_latency", n, 3);
    check("mid_reack_raw", raw_cnt, 16'h0001);
    smp_req = 1'b0;
    n = 0;
    while (smp_ack && n < 20) begin @(negedge clk); n++; end
    base = vld_cnt;
    for (int i = 0; i < 31; i++) send(0, 16'h0000);
    repeat (3) @(negedge clk);
    check("mid_word_fresh", last_word, 32'h0000_0001);
    check("mid_word_count", vld_cnt - base, 1);

    // 4 bits per sample into a 16-bit word
    base = vld_cnt2;
    for (int i = 1; i <= 4; i++) send(1, 16'(i));
    repeat (3) @(negedge clk);
    check("bps4_word", last_word2, 16'h4321);
    check("bps4_count", vld_cnt2 - base, 1);

    // Repetition count test
    do_reset();
    for (int i = 0; i < 7; i++) send(0, 16'h0003);
    check("rct_seven", health_alarm, 0);
    send(0, 16'h0003);
    check("rct_eighth", health_alarm, RCT_EXP);
    send(0, 16'h0004);
    check("rct_sticky", health_alarm, RCT_EXP);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rct_cleared", health_alarm, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
